// File: rtl/spi_accel_pkg.sv
// Register map, reset values, FSM encoding and read-mux helper shared by the
// accelerometer SPI responder.
package spi_accel_pkg;

  localparam logic [5:0] AddrDevid      = 6'h00;
  localparam logic [5:0] AddrBwRate     = 6'h2C;
  localparam logic [5:0] AddrPowerCtl   = 6'h2D;
  localparam logic [5:0] AddrDataFormat = 6'h31;
  localparam logic [5:0] AddrDataX0     = 6'h32;
  localparam logic [5:0] AddrDataX1     = 6'h33;
  localparam logic [5:0] AddrDataY0     = 6'h34;
  localparam logic [5:0] AddrDataY1     = 6'h35;
  localparam logic [5:0] AddrDataZ0     = 6'h36;
  localparam logic [5:0] AddrDataZ1     = 6'h37;

  localparam logic [7:0] DevidVal      = 8'hE5;
  localparam logic [7:0] BwRateRst     = 8'h0A;
  localparam logic [7:0] PowerCtlRst   = 8'h00;
  localparam logic [7:0] DataFormatRst = 8'h00;

  typedef enum logic [1:0] {StIdle, StAddr, StData, StDone} state_e;

  // High byte of an axis is the sign-extended top two bits.
  function automatic logic [7:0] reg_read(input logic [5:0] addr,
                                          input logic [9:0] x,
                                          input logic [9:0] y,
                                          input logic [9:0] z,
                                          input logic [7:0] bw_rate,
                                          input logic [7:0] power_ctl,
                                          input logic [7:0] data_format);
    logic [7:0] v;
    v = 8'h00;
    case (addr)
      AddrDevid:      v = DevidVal;
      AddrBwRate:     v = bw_rate;
      AddrPowerCtl:   v = power_ctl;
      AddrDataFormat: v = data_format;
      AddrDataX0:     v = x[7:0];
      AddrDataX1:     v = {{6{x[9]}}, x[9:8]};
      AddrDataY0:     v = y[7:0];
      AddrDataY1:     v = {{6{y[9]}}, y[9:8]};
      AddrDataZ0:     v = z[7:0];
      AddrDataZ1:     v = {{6{z[9]}}, z[9:8]};
      default:        v = 8'h00;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/spi_accel_responder_if.sv
// SPI pins between the master controller and the accelerometer responder.
interface spi_accel_responder_if;
  logic sclk;
  logic ss_n;
  logic mosi;
  logic miso;
  logic miso_oe;

  modport master (output sclk, output ss_n, output mosi, input miso, input miso_oe);
  modport slave  (input sclk, input ss_n, input mosi, output miso, output miso_oe);
endinterface

// File: rtl/spi_sync_edge.sv
// 2-FF synchronizer with an extra history stage producing one-clk rise/fall pulses.
module spi_sync_edge #(
  parameter bit ResetVal = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic [2:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {3{ResetVal}};
    end else begin
      sync_q <= {sync_q[1:0], d};
    end
  end

  assign rise = sync_q[1] & ~sync_q[2];
  assign fall = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/spi_accel_responder.sv
// ADXL345-style SPI mode-3 responder serving a fixed register map.
// Optional SPI_RESP_MULTIBYTE_EN enables MB auto-increment bursts.
module spi_accel_responder
  import spi_accel_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  spi_accel_responder_if.slave spi,
  input  logic [9:0]           x_in,
  input  logic [9:0]           y_in,
  input  logic [9:0]           z_in,
  output logic [7:0]           power_ctl,
  output logic [7:0]           bw_rate,
  output logic [7:0]           data_format,
  output logic                 wr_strobe,
  output logic                 frame_done
);

  logic sclk_rise, sclk_fall, ss_rise, ss_fall;
  logic [1:0] mosi_sync_q;
  logic mosi_s;

  spi_sync_edge #(.ResetVal(1'b1)) u_sclk_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (spi.sclk),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  // Resetting low means a select held low across reset never looks like a new frame.
  spi_sync_edge #(.ResetVal(1'b0)) u_ss_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (spi.ss_n),
    .rise (ss_rise),
    .fall (ss_fall)
  );

  state_e     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       seen8_q, seen8_d;
  logic [7:0] shift_in_q, shift_in_d;
  logic [7:0] shift_out_q, shift_out_d;
  logic [5:0] addr_q, addr_d;
  logic       rnw_q, rnw_d;
`ifdef SPI_RESP_MULTIBYTE_EN
  logic       mb_q, mb_d;
`endif
  logic [9:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic [7:0] bw_q, bw_d, pc_q, pc_d, df_q, df_d;
  logic       miso_q, miso_d, oe_q, oe_d;
  logic       wr_q, wr_d, fd_q, fd_d;
  logic [7:0] mosi_byte;

  assign mosi_s    = mosi_sync_q[1];
  assign mosi_byte = {shift_in_q[6:0], mosi_s};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mosi_sync_q <= 2'b00;
      state_q     <= StIdle;
      bit_cnt_q   <= 3'd0;
      seen8_q     <= 1'b0;
      shift_in_q  <= 8'h00;
      shift_out_q <= 8'h00;
      addr_q      <= 6'h00;
      rnw_q       <= 1'b0;
`ifdef SPI_RESP_MULTIBYTE_EN
      mb_q        <= 1'b0;
`endif
      x_q         <= 10'h000;
      y_q         <= 10'h000;
      z_q         <= 10'h000;
      bw_q        <= BwRateRst;
      pc_q        <= PowerCtlRst;
      df_q        <= DataFormatRst;
      miso_q      <= 1'b0;
      oe_q        <= 1'b0;
      wr_q        <= 1'b0;
      fd_q        <= 1'b0;
    end else begin
      mosi_sync_q <= {mosi_sync_q[0], spi.mosi};
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      seen8_q     <= seen8_d;
      shift_in_q  <= shift_in_d;
      shift_out_q <= shift_out_d;
      addr_q      <= addr_d;
      rnw_q       <= rnw_d;
`ifdef SPI_RESP_MULTIBYTE_EN
      mb_q        <= mb_d;
`endif
      x_q         <= x_d;
      y_q         <= y_d;
      z_q         <= z_d;
      bw_q        <= bw_d;
      pc_q        <= pc_d;
      df_q        <= df_d;
      miso_q      <= miso_d;
      oe_q        <= oe_d;
      wr_q        <= wr_d;
      fd_q        <= fd_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    seen8_d     = seen8_q;
    shift_in_d  = shift_in_q;
    shift_out_d = shift_out_q;
    addr_d      = addr_q;
    rnw_d       = rnw_q;
`ifdef SPI_RESP_MULTIBYTE_EN
    mb_d        = mb_q;
`endif
    x_d         = x_q;
    y_d         = y_q;
    z_d         = z_q;
    bw_d        = bw_q;
    pc_d        = pc_q;
    df_d        = df_q;
    miso_d      = miso_q;
    oe_d        = oe_q;
    wr_d        = 1'b0;
    fd_d        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (ss_fall) begin
          state_d   = StAddr;
          bit_cnt_d = 3'd0;
          seen8_d   = 1'b0;
          oe_d      = 1'b1;
          miso_d    = 1'b0;
          x_d       = x_in;
          y_d       = y_in;
          z_d       = z_in;
        end
      end
      StAddr: begin
        if (sclk_rise) begin
          shift_in_d = mosi_byte;
          bit_cnt_d  = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            rnw_d       = mosi_byte[7];
`ifdef SPI_RESP_MULTIBYTE_EN
            mb_d        = mosi_byte[6];
`endif
            addr_d      = mosi_byte[5:0];
            seen8_d     = 1'b1;
            state_d     = StData;
            shift_out_d = reg_read(mosi_byte[5:0], x_q, y_q, z_q, bw_q, pc_q, df_q);
          end
        end
      end
      StData: begin
        if (sclk_fall && rnw_q) begin
          miso_d      = shift_out_q[7];
          shift_out_d = {shift_out_q[6:0], 1'b0};
        end else if (sclk_rise) begin
          shift_in_d = mosi_byte;
          bit_cnt_d  = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (!rnw_q) begin
              case (addr_q)
                AddrBwRate:     begin bw_d = mosi_byte; wr_d = 1'b1; end
                AddrPowerCtl:   begin pc_d = mosi_byte; wr_d = 1'b1; end
                AddrDataFormat: begin df_d = mosi_byte; wr_d = 1'b1; end
                default:        ;
              endcase
            end
`ifdef SPI_RESP_MULTIBYTE_EN
            if (mb_q) begin
              addr_d      = addr_q + 6'd1;
              shift_out_d = reg_read(addr_q + 6'd1, x_q, y_q, z_q, bw_q, pc_q, df_q);
            end else begin
              state_d = StDone;
            end
`else
            state_d = StDone;
`endif
          end
        end
      end
      StDone: begin
        miso_d = 1'b0;
      end
      default: state_d = StIdle;
    endcase

    // Frame end overrides the state only; a same-cycle byte commit above still lands.
    if (state_q != StIdle && ss_rise) begin
      state_d = StIdle;
      fd_d    = seen8_d;
      oe_d    = 1'b0;
      miso_d  = 1'b0;
    end
  end

  assign spi.miso    = miso_q;
  assign spi.miso_oe = oe_q;
  assign power_ctl   = pc_q;
  assign bw_rate     = bw_q;
  assign data_format = df_q;
  assign wr_strobe   = wr_q;
  assign frame_done  = fd_q;

endmodule

// File: tb/tb_spi_accel_responder.sv
// Randomized self-checking bench for spi_accel_responder against a register-map model.
module tb_spi_accel_responder;

`ifdef SPI_RESP_MULTIBYTE_EN
  localparam bit MbBuild = 1'b1;
`else
  localparam bit MbBuild = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic [9:0] x_in, y_in, z_in;
  logic [7:0] power_ctl, bw_rate, data_format;
  logic wr_strobe, frame_done;

  always #5 clk = ~clk;

  spi_accel_responder_if spi_bus ();

  spi_accel_responder dut (
    .clk         (clk),
    .rst         (rst),
    .spi         (spi_bus),
    .x_in        (x_in),
    .y_in        (y_in),
    .z_in        (z_in),
    .power_ctl   (power_ctl),
    .bw_rate     (bw_rate),
    .data_format (data_format),
    .wr_strobe   (wr_strobe),
    .frame_done  (frame_done)
  );

  int tests = 0;
  int fails = 0;
  int fd_cnt = 0;
  int wr_cnt = 0;

  always @(posedge clk) begin
    if (frame_done) fd_cnt++;
    if (wr_strobe) wr_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural register model
  logic [7:0] m_bw, m_pc, m_df;

  task automatic model_reset();
    m_bw = 8'h0A;
    m_pc = 8'h00;
    m_df = 8'h00;
  endtask

  function automatic logic [7:0] model_read(input int a, input int sx, input int sy, input int sz);
    int s;
    int v;
    if (a == 'h00) return 8'hE5;
    if (a == 'h2C) return m_bw;
    if (a == 'h2D) return m_pc;
    if (a == 'h31) return m_df;
    if (a < 'h32 || a > 'h37) return 8'h00;
    s = ((a - 'h32) / 2 == 0) ? sx : (((a - 'h32) / 2 == 1) ? sy : sz);
    v = (s >= 512) ? s - 1024 : s;
    if ((a - 'h32) % 2 == 0) return 8'(v & 255);
    return 8'((v >>> 8) & 255);
  endfunction

  logic [7:0] tx [0:7];
  logic [7:0] rx [0:7];

  task automatic spi_bit(input int i);
    spi_bus.sclk = 1'b0;
    spi_bus.mosi = tx[i / 8][7 - (i % 8)];
    repeat (8) @(negedge clk);
    spi_bus.sclk = 1'b1;
    rx[i / 8][7 - (i % 8)] = spi_bus.miso;
    repeat (8) @(negedge clk);
  endtask

  // nbits total bits; inputs re-randomized at chg_bit; reset pulsed at rst_bit
  task automatic run_frame(input int nbits, input int chg_bit, input int rst_bit);
    int fd0, wr0, sx, sy, sz, nfull, exp_wr, aa;
    logic r, mb;
    logic [5:0] a;
    fd0 = fd_cnt;
    wr0 = wr_cnt;
    sx = int'(x_in);
    sy = int'(y_in);
    sz = int'(z_in);
    for (int k = 0; k < 8; k++) rx[k] = 8'h00;
    spi_bus.ss_n = 1'b0;
    repeat (8) @(negedge clk);
    if (rst_bit < 0) check_eq("oe_active", 32'(spi_bus.miso_oe), 32'd1);
    for (int i = 0; i < nbits; i++) begin
      if (i == chg_bit) begin
        x_in = 10'($urandom);
        y_in = 10'($urandom);
        z_in = 10'($urandom);
      end
      if (i == rst_bit) begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_oe", 32'(spi_bus.miso_oe), 32'd0);
        check_eq("rst_miso", 32'(spi_bus.miso), 32'd0);
        check_eq("rst_pc", 32'(power_ctl), 32'h00);
        check_eq("rst_bw", 32'(bw_rate), 32'h0A);
        check_eq("rst_df", 32'(data_format), 32'h00);
        check_eq("rst_pulses", 32'({wr_strobe, frame_done}), 32'd0);
        rst = 1'b0;
        model_reset();
      end
      spi_bit(i);
    end
    spi_bus.ss_n = 1'b1;
    spi_bus.mosi = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("oe_idle", 32'(spi_bus.miso_oe), 32'd0);

    exp_wr = 0;
    if (rst_bit < 0) begin
      r = tx[0][7];
      mb = tx[0][6];
      a = tx[0][5:0];
      nfull = (nbits - 8) / 8;
      check_eq("miso_addr", 32'(rx[0]), 32'h00);
      for (int k = 0; k < nfull; k++) begin
        if (k > 0 && !(MbBuild && mb)) begin
          if (r) check_eq("miso_done", 32'(rx[k + 1]), 32'h00);
        end else begin
          aa = (int'(a) + k) % 64;
          if (r) begin
            check_eq($sformatf("rd_%02h", aa), 32'(rx[k + 1]), 32'(model_read(aa, sx, sy, sz)));
          end else if (aa == 'h2C) begin m_bw = tx[k + 1]; exp_wr++; end
          else if (aa == 'h2D) begin m_pc = tx[k + 1]; exp_wr++; end
          else if (aa == 'h31) begin m_df = tx[k + 1]; exp_wr++; end
        end
      end
    end
    check_eq("frame_done", 32'(fd_cnt - fd0), (rst_bit < 0 && nbits >= 8) ? 32'd1 : 32'd0);
    check_eq("wr_strobe", 32'(wr_cnt - wr0), 32'(exp_wr));
    check_eq("power_ctl", 32'(power_ctl), 32'(m_pc));
    check_eq("bw_rate", 32'(bw_rate), 32'(m_bw));
    check_eq("data_format", 32'(data_format), 32'(m_df));
  endtask

  task automatic frame2(input logic [7:0] b0, input logic [7:0] b1, input int nbits);
    tx[0] = b0;
    tx[1] = b1;
    for (int k = 2; k < 8; k++) tx[k] = 8'($urandom);
    run_frame(nbits, -1, -1);
  endtask

  logic [5:0] addr_tab [0:9];

  initial begin
    addr_tab = '{6'h00, 6'h2C, 6'h2D, 6'h31, 6'h32, 6'h33, 6'h34, 6'h35, 6'h36, 6'h37};
    rst = 1'b1;
    spi_bus.sclk = 1'b1;
    spi_bus.ss_n = 1'b1;
    spi_bus.mosi = 1'b0;
    x_in = 10'h000;
    y_in = 10'h000;
    z_in = 10'h000;
    model_reset();
    repeat (5) @(negedge clk);
    check_eq("reset_miso", 32'(spi_bus.miso), 32'd0);
    check_eq("reset_oe", 32'(spi_bus.miso_oe), 32'd0);
    check_eq("reset_bw", 32'(bw_rate), 32'h0A);
    check_eq("reset_pc", 32'(power_ctl), 32'h00);
    check_eq("reset_df", 32'(data_format), 32'h00);
    check_eq("reset_pulses", 32'({wr_strobe, frame_done}), 32'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    frame2(8'h80, 8'h00, 16);               // DEVID
    frame2(8'h2D, 8'h08, 16);
    frame2(8'h2C, 8'h08, 16);
    frame2(8'hAC, 8'h00, 16);
    x_in = 10'h3F6;
    frame2(8'hB2, 8'h00, 16);
    frame2(8'hB3, 8'h00, 16);
    x_in = 10'h105;
    frame2(8'hB2, 8'h00, 16);
    frame2(8'hB3, 8'h00, 16);

    // Burst read with inputs changing mid-frame
    x_in = 10'($urandom);
    y_in = 10'($urandom);
    z_in = 10'($urandom);
    tx[0] = 8'hF2;
    for (int k = 1; k < 8; k++) tx[k] = 8'h00;
    run_frame(56, 20, -1);

    frame2(8'h31, 8'h55, 12);               // aborted write
    frame2(8'h00, 8'h12, 16);
    frame2(8'h80, 8'h00, 16);
    frame2(8'h31, 8'h05, 16);

    tx[0] = 8'h31;
    tx[1] = 8'h77;
    run_frame(16, -1, 11);                  // reset mid data byte
    frame2(8'h31, 8'h0B, 16);
    frame2(8'hB1, 8'h00, 16);

    for (int n = 0; n < 40; n++) begin
      int pick;
      int nbits;
      logic [5:0] a;
      pick = $urandom_range(0, 11);
      a = (pick < 10) ? addr_tab[pick] : 6'($urandom);
      x_in = 10'($urandom);
      y_in = 10'($urandom);
      z_in = 10'($urandom);
      tx[0] = {1'($urandom), 1'($urandom), a};
      for (int k = 1; k < 8; k++) tx[k] = 8'($urandom);
      nbits = 8 + 8 * $urandom_range(1, 4);
      if ($urandom_range(0, 4) == 0) nbits += $urandom_range(1, 7);
      run_frame(nbits, ($urandom_range(0, 2) == 0) ? 4 : -1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
